// File: rtl/hart_mem_arbiter.sv
// hart_mem_arbiter: round-robin arbiter sharing one memory port between instruction
// fetch and data access, with a wait-cycle timeout that aborts stalled transfers.
`default_nettype none

module hart_mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ic_req,
    input  logic [XLEN-1:0] i_ic_addr,
    output logic            o_ic_ready,
    output logic [XLEN-1:0] o_ic_rdata,
    output logic            o_ic_err,
    input  logic            i_dm_req,
    input  logic            i_dm_wen,
    input  logic [XLEN-1:0] i_dm_addr,
    input  logic [XLEN-1:0] i_dm_wdata,
    input  logic [2:0]      i_dm_f3,
    output logic            o_dm_ready,
    output logic [XLEN-1:0] o_dm_rdata,
    output logic            o_dm_err,
    output logic            o_mem_req,
    output logic            o_mem_wen,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [2:0]      o_mem_f3,
    input  logic            i_mem_ready,
    input  logic [XLEN-1:0] i_mem_rdata
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IC_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       last_dm;
    logic       resp_dm;
    logic       resp_err;
    logic [7:0] wait_cnt;
    logic       grant_ic;
    logic       grant_dm;
    logic       busy;
    logic       timeout_hit;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        // On a tie, the side that was not served last wins.
        grant_ic    = i_ic_req && (!i_dm_req || last_dm);
        grant_dm    = i_dm_req && !grant_ic;
        busy        = (state == IC_BUSY) || (state == DM_BUSY);
        timeout_hit = busy && !i_mem_ready && (wait_cnt == TMO_LAST);
        case (state)
            IDLE: begin
                if (grant_ic) begin
                    state_nxt = IC_BUSY;
                end else if (grant_dm) begin
                    state_nxt = DM_BUSY;
                end
            end
            IC_BUSY, DM_BUSY: begin
                if (i_mem_ready || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_mem_req   <= 1'b0;
            o_mem_wen   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_f3    <= 3'b000;
            o_ic_rdata  <= '0;
            o_dm_rdata  <= '0;
            wait_cnt    <= 8'd0;
            last_dm     <= 1'b1;
            resp_dm     <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= 8'd0;
                    if (grant_ic) begin
                        o_mem_req   <= 1'b1;
                        o_mem_wen   <= 1'b0;
                        o_mem_addr  <= i_ic_addr;
                        o_mem_wdata <= '0;
                        o_mem_f3    <= 3'b010;
                        resp_dm     <= 1'b0;
                    end else if (grant_dm) begin
                        o_mem_req   <= 1'b1;
                        o_mem_wen   <= i_dm_wen;
                        o_mem_addr  <= i_dm_addr;
                        o_mem_wdata <= i_dm_wdata;
                        o_mem_f3    <= i_dm_f3;
                        resp_dm     <= 1'b1;
                    end
                end
                IC_BUSY, DM_BUSY: begin
                    // Completion takes priority over a coincident timeout.
                    if (i_mem_ready) begin
                        o_mem_req <= 1'b0;
                        resp_err  <= 1'b0;
                        last_dm   <= (state == DM_BUSY);
                        if (state == IC_BUSY) begin
                            o_ic_rdata <= i_mem_rdata;
                        end else if (!o_mem_wen) begin
                            o_dm_rdata <= i_mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        o_mem_req <= 1'b0;
                        resp_err  <= 1'b1;
                        last_dm   <= (state == DM_BUSY);
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ic_ready = (state == RESP) && !resp_dm;
    assign o_dm_ready = (state == RESP) && resp_dm;
    assign o_ic_err   = o_ic_ready && resp_err;
    assign o_dm_err   = o_dm_ready && resp_err;

endmodule

`default_nettype wire

// File: tb/tb_hart_mem_arbiter.sv
// tb_hart_mem_arbiter: directed stimulus with a response scoreboard for hart_mem_arbiter.
`default_nettype none

module tb_hart_mem_arbiter;

    localparam int XLEN = 32;
    localparam int TMO  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ic_req;
    logic [XLEN-1:0] ic_addr;
    logic            ic_ready;
    logic [XLEN-1:0] ic_rdata;
    logic            ic_err;
    logic            dm_req;
    logic            dm_wen;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic [2:0]      dm_f3;
    logic            dm_ready;
    logic [XLEN-1:0] dm_rdata;
    logic            dm_err;
    logic            mem_req;
    logic            mem_wen;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [2:0]      mem_f3;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    always #5 clk = ~clk;

    hart_mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_ic_req(ic_req), .i_ic_addr(ic_addr),
        .o_ic_ready(ic_ready), .o_ic_rdata(ic_rdata), .o_ic_err(ic_err),
        .i_dm_req(dm_req), .i_dm_wen(dm_wen), .i_dm_addr(dm_addr),
        .i_dm_wdata(dm_wdata), .i_dm_f3(dm_f3),
        .o_dm_ready(dm_ready), .o_dm_rdata(dm_rdata), .o_dm_err(dm_err),
        .o_mem_req(mem_req), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_f3(mem_f3),
        .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic        dm;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] ic_model = '0;
    logic [31:0] dm_model = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        resp_t e;
        if (ic_ready || dm_ready) begin
            check("ready_excl", 128'(ic_ready & dm_ready), 128'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 128'd1, 128'd0);
            end else begin
                e = exp_q.pop_front();
                check("ready_side", 128'(dm_ready), 128'(e.dm));
                check("rdata", 128'(e.dm ? dm_rdata : ic_rdata), 128'(e.rdata));
                check("err", 128'(e.dm ? dm_err : ic_err), 128'(e.err));
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        ic_req = 1'b0; ic_addr = '0;
        dm_req = 1'b0; dm_wen = 1'b0; dm_addr = '0; dm_wdata = '0; dm_f3 = 3'b000;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        ic_model = '0;
        dm_model = '0;
        check("rst_outs", {ic_ready, ic_err, dm_ready, dm_err, mem_req, mem_wen, mem_f3},
              128'd0);
        check("rst_data", {ic_rdata, dm_rdata, mem_addr, mem_wdata}, 128'd0);
        rst_n = 1'b1;
    endtask

    // Waits for the memory request, checks the presented fields each cycle, then completes it.
    task automatic serve(input logic dm, input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input logic [31:0] data, input int lat, input string tag);
        int          n = 0;
        logic [31:0] exp_rd;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_memreq"}, 128'(mem_req), 128'd1);
        for (int i = 0; i <= lat; i++) begin
            if (i > 0) @(negedge clk);
            check({tag, "_fields"}, {mem_req, mem_wen, mem_f3, mem_addr, mem_wdata},
                  {1'b1, wen, f3, addr, wdata});
        end
        mem_ready = 1'b1;
        mem_rdata = data;
        if (dm && wen) begin
            exp_rd = dm_model;
        end else begin
            exp_rd = data;
            if (dm) dm_model = data;
            else    ic_model = data;
        end
        exp_q.push_back('{dm: dm, rdata: exp_rd, err: 1'b0});
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = 32'h0BAD_0BAD;
        check({tag, "_memreq_drop"}, 128'(mem_req), 128'd0);
        check({tag, "_pulse"}, 128'(dm ? dm_ready : ic_ready), 128'd1);
    endtask

    initial begin
        int n;
        int cnt;

        // Fetch immediately after reset: single-cycle memory.
        do_reset();
        ic_req  = 1'b1;
        ic_addr = 32'h100;
        @(negedge clk);
        check("first_grant_latency", 128'(mem_req), 128'd1);
        serve(1'b0, 32'h100, 1'b0, 32'h0, 3'b010, 32'hDEADBEEF, 0, "ic_basic");
        ic_req = 1'b0;

        // Both held from reset: IC, DM, IC, DM.
        do_reset();
        ic_req = 1'b1; ic_addr = 32'h300;
        dm_req = 1'b1; dm_wen = 1'b0; dm_addr = 32'h400; dm_wdata = 32'hCAFE; dm_f3 = 3'b100;
        serve(1'b0, 32'h300, 1'b0, 32'h0,    3'b010, 32'h1111_0001, 1, "rr0_ic");
        serve(1'b1, 32'h400, 1'b0, 32'hCAFE, 3'b100, 32'h2222_0002, 1, "rr1_dm");
        serve(1'b0, 32'h300, 1'b0, 32'h0,    3'b010, 32'h3333_0003, 0, "rr2_ic");
        serve(1'b1, 32'h400, 1'b0, 32'hCAFE, 3'b100, 32'h4444_0004, 2, "rr3_dm");
        ic_req = 1'b0;
        dm_req = 1'b0;

        // DM write: read data must stay at the last DM read value.
        @(negedge clk);
        dm_req = 1'b1; dm_wen = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'h55AA; dm_f3 = 3'b001;
        serve(1'b1, 32'h2000, 1'b1, 32'h55AA, 3'b001, 32'hFFFF_FFFF, 2, "dm_write");
        dm_req = 1'b0; dm_wen = 1'b0;

        // Ready arriving on the final allowed cycle is a normal completion.
        @(negedge clk);
        ic_req = 1'b1; ic_addr = 32'h180;
        serve(1'b0, 32'h180, 1'b0, 32'h0, 3'b010, 32'hA5A5_5A5A, TMO - 1, "edge_tmo");
        ic_req = 1'b0;

        // Memory never answers: abort with err after TMO request cycles.
        @(negedge clk);
        dm_req = 1'b1; dm_wen = 1'b0; dm_addr = 32'h3000; dm_f3 = 3'b010;
        exp_q.push_back('{dm: 1'b1, rdata: dm_model, err: 1'b1});
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        cnt = 0;
        while (mem_req && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        check("tmo_req_cycles", 128'(cnt), 128'(TMO));
        check("tmo_pulse", {dm_ready, dm_err}, 128'b11);
        dm_req = 1'b0;

        // Spurious memory ready while idle must not produce a response.
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'h0000_0BAD;
        @(negedge clk);
        mem_ready = 1'b0;
        check("spurious_no_pulse", {ic_ready, dm_ready, ic_rdata}, {2'b00, ic_model});
        ic_req = 1'b1; ic_addr = 32'h600;
        serve(1'b0, 32'h600, 1'b0, 32'h0, 3'b010, 32'h0000_600D, 2, "after_spurious");
        ic_req = 1'b0;

        // Reset in the middle of a DM transaction abandons it.
        @(negedge clk);
        dm_req = 1'b1; dm_wen = 1'b0; dm_addr = 32'h4000; dm_f3 = 3'b010;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", {mem_req, dm_ready, ic_ready, dm_rdata, mem_addr},
              128'd0);
        dm_req = 1'b0;
        ic_model = '0;
        dm_model = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ic_req = 1'b1; ic_addr = 32'h500;
        serve(1'b0, 32'h500, 1'b0, 32'h0, 3'b010, 32'h0000_0077, 1, "after_rst");
        ic_req = 1'b0;

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
